// File: rtl/dif_pair_buf.sv
// Radix-2 DIF input commutator: buffers the first half of each frame and pairs it with the second half.
// Optional build macro DIF_PAIR_BUF_OUT_REG_EN adds one output register stage, giving a latency of 3 instead of 2.
module dif_pair_buf #(
    parameter int IN_W         = 10,
    parameter int STAGE        = 0,
    parameter int TOTAL_STAGES = 8
) (
    input  logic                   mclk,
    input  logic                   rst_n,
    input  logic                   i_init,
    input  logic                   i_vld,
    input  logic signed [IN_W-1:0] i_I,
    input  logic signed [IN_W-1:0] i_Q,
    output logic                   o_vld,
    output logic signed [IN_W-1:0] o_LI,
    output logic signed [IN_W-1:0] o_LQ,
    output logic signed [IN_W-1:0] o_RI,
    output logic signed [IN_W-1:0] o_RQ,
    output logic                   o_half,
    output logic                   o_frame_strb
);

    localparam int STAGE_FFT_LEN = 2 ** (TOTAL_STAGES - STAGE);
    localparam int HALF          = STAGE_FFT_LEN / 2;
    localparam int A_W           = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int D_W           = 2 * IN_W;
    localparam logic [A_W-1:0] LAST = A_W'(HALF - 1);

    logic [A_W-1:0] idx;
    logic           phase;
    logic           wr_en;
    logic           rd_en;

    logic [D_W-1:0] mem [2**A_W];
    logic [D_W-1:0] rd_data;
    logic [D_W-1:0] r_dly;
    logic           v1;
    logic           fs1;

    logic           s2_vld;
    logic           s2_fs;
    logic [D_W-1:0] s2_l;
    logic [D_W-1:0] s2_r;

    // Soft init has priority over a valid sample, so an init cycle neither writes nor reads.
    assign wr_en = i_vld & ~i_init & ~phase;
    assign rd_en = i_vld & ~i_init &  phase;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            phase <= 1'b0;
        end else if (i_init) begin
            idx   <= '0;
            phase <= 1'b0;
        end else if (i_vld) begin
            if (idx == LAST) begin
                idx   <= '0;
                phase <= ~phase;
            end else begin
                idx <= idx + A_W'(1);
            end
        end
    end

    // NOTE: the RAM and its read/delay registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge mclk) begin
        if (wr_en)
            mem[idx] <= {i_I, i_Q};
        if (rd_en) begin
            rd_data <= mem[idx];
            r_dly   <= {i_I, i_Q};
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            fs1 <= 1'b0;
        end else begin
            v1  <= rd_en;
            fs1 <= rd_en & (idx == LAST);
        end
    end

    // The output stage loads only on a valid pair, so data holds between strobes.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            s2_fs  <= 1'b0;
            s2_l   <= '0;
            s2_r   <= '0;
        end else begin
            s2_vld <= v1;
            s2_fs  <= v1 & fs1;
            if (v1) begin
                s2_l <= rd_data;
                s2_r <= r_dly;
            end
        end
    end

`ifdef DIF_PAIR_BUF_OUT_REG_EN
    logic           s3_vld;
    logic           s3_fs;
    logic [D_W-1:0] s3_l;
    logic [D_W-1:0] s3_r;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld <= 1'b0;
            s3_fs  <= 1'b0;
            s3_l   <= '0;
            s3_r   <= '0;
        end else begin
            s3_vld <= s2_vld;
            s3_fs  <= s2_fs;
            if (s2_vld) begin
                s3_l <= s2_l;
                s3_r <= s2_r;
            end
        end
    end

    assign o_vld        = s3_vld;
    assign o_frame_strb = s3_fs;
    assign o_LI         = s3_l[D_W-1:IN_W];
    assign o_LQ         = s3_l[IN_W-1:0];
    assign o_RI         = s3_r[D_W-1:IN_W];
    assign o_RQ         = s3_r[IN_W-1:0];
`else
    assign o_vld        = s2_vld;
    assign o_frame_strb = s2_fs;
    assign o_LI         = s2_l[D_W-1:IN_W];
    assign o_LQ         = s2_l[IN_W-1:0];
    assign o_RI         = s2_r[D_W-1:IN_W];
    assign o_RQ         = s2_r[IN_W-1:0];
`endif

    assign o_half = phase;

endmodule

// File: tb/tb_dif_pair_buf.sv
// Bench for dif_pair_buf: a frame-level pairing model checked every cycle, plus hand-computed literals.
// The main instance uses an 8-point stage; a second instance uses a 2-point stage.
module tb_dif_pair_buf;

`ifdef DIF_PAIR_BUF_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int N    = 8;
    localparam int HALF = N / 2;

    typedef struct {
        int due;
        int li, lq, ri, rq;
        bit fs;
    } pair_t;

    typedef struct {
        int li, ri;
        bit fs;
    } got_t;

    logic mclk = 1'b0;
    logic rst_n = 1'b0;
    logic i_init = 1'b0;
    logic i_vld = 1'b0;
    logic signed [9:0] i_I = '0, i_Q = '0;
    logic o_vld, o_half, o_frame_strb;
    logic signed [9:0] o_LI, o_LQ, o_RI, o_RQ;

    logic i2_vld = 1'b0;
    logic signed [9:0] i2_I = '0, i2_Q = '0;
    logic o2_vld, o2_half, o2_frame_strb;
    logic signed [9:0] o2_LI, o2_LQ, o2_RI, o2_RQ;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int vld_cnt = 0;

    int pos = 0;
    int fbuf_i [HALF];
    int fbuf_q [HALF];
    pair_t exp_q [$];
    pair_t cur;
    int last_li = 0, last_lq = 0, last_ri = 0, last_rq = 0;
    bit exp_vld;
    bit exp_fs;
    got_t got2 [$];

    dif_pair_buf #(.IN_W(10), .STAGE(5), .TOTAL_STAGES(8)) u_dut (
        .mclk(mclk), .rst_n(rst_n), .i_init(i_init), .i_vld(i_vld),
        .i_I(i_I), .i_Q(i_Q), .o_vld(o_vld),
        .o_LI(o_LI), .o_LQ(o_LQ), .o_RI(o_RI), .o_RQ(o_RQ),
        .o_half(o_half), .o_frame_strb(o_frame_strb)
    );

    dif_pair_buf #(.IN_W(10), .STAGE(7), .TOTAL_STAGES(8)) u_dut2 (
        .mclk(mclk), .rst_n(rst_n), .i_init(i_init), .i_vld(i2_vld),
        .i_I(i2_I), .i_Q(i2_Q), .o_vld(o2_vld),
        .o_LI(o2_LI), .o_LQ(o2_LQ), .o_RI(o2_RI), .o_RQ(o2_RQ),
        .o_half(o2_half), .o_frame_strb(o2_frame_strb)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: sample p < HALF of a frame is stored; sample p >= HALF produces pair (p-HALF, p).
    always @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            pos = 0;
            exp_q.delete();
        end else begin
            cyc++;
            if (i_init) begin
                pos = 0;
            end else if (i_vld) begin
                if (pos < HALF) begin
                    fbuf_i[pos] = int'(i_I);
                    fbuf_q[pos] = int'(i_Q);
                end else begin
                    exp_q.push_back('{due: cyc + LAT - 1,
                                      li: fbuf_i[pos-HALF], lq: fbuf_q[pos-HALF],
                                      ri: int'(i_I), rq: int'(i_Q), fs: (pos == N - 1)});
                end
                pos = (pos + 1) % N;
            end
        end
    end

    always @(negedge mclk) begin
        exp_vld = 1'b0;
        exp_fs  = 1'b0;
        if (!rst_n) begin
            last_li = 0; last_lq = 0; last_ri = 0; last_rq = 0;
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            cur = exp_q.pop_front();
            exp_vld = 1'b1;
            exp_fs  = cur.fs;
            last_li = cur.li; last_lq = cur.lq; last_ri = cur.ri; last_rq = cur.rq;
        end
        check("o_vld", o_vld, exp_vld);
        check("o_frame_strb", o_frame_strb, exp_fs);
        check("o_half", o_half, (pos >= HALF));
        check("o_LI", o_LI, last_li);
        check("o_LQ", o_LQ, last_lq);
        check("o_RI", o_RI, last_ri);
        check("o_RQ", o_RQ, last_rq);
        if (o_vld) vld_cnt++;
        if (o2_vld) got2.push_back('{li: int'(o2_LI), ri: int'(o2_RI), fs: o2_frame_strb});
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic send(input int vi, input int vq, input int gap, input bit init);
        i_vld  = 1'b1;
        i_init = init;
        i_I    = 10'(vi);
        i_Q    = 10'(vq);
        idle(1);
        i_vld  = 1'b0;
        i_init = 1'b0;
        idle(gap);
    endtask

    task automatic send2(input int v);
        i2_vld = 1'b1;
        i2_I   = 10'(v);
        i2_Q   = 10'(-v);
        idle(1);
        i2_vld = 1'b0;
    endtask

    int gaps [8] = '{2, 0, 5, 1, 3, 0, 4, 2};

    initial begin
        idle(2);
        check("rst_o_vld", o_vld, 0);
        check("rst_o_half", o_half, 0);
        check("rst_o_LI", o_LI, 0);
        check("rst_o_frame_strb", o_frame_strb, 0);
        rst_n = 1'b1;
        idle(2);

        // Continuous frame
        for (int k = 0; k < 8; k++) send(k, -k, 0, 1'b0);
        idle(LAT + 1);
        check("t1_pairs", vld_cnt, 4);
        check("t1_LI", o_LI, 3);
        check("t1_LQ", o_LQ, -3);
        check("t1_RI", o_RI, 7);
        check("t1_RQ", o_RQ, -7);

        // Gapped frame
        for (int k = 0; k < 8; k++) send(k, -k, gaps[k], 1'b0);
        idle(LAT + 1);
        check("t2_pairs", vld_cnt, 8);
        check("t2_RI", o_RI, 7);

        // Two frames back to back
        for (int k = 0; k < 16; k++) send(k, -k, 0, 1'b0);
        idle(LAT + 1);
        check("t3_pairs", vld_cnt, 16);
        check("t3_LI", o_LI, 11);
        check("t3_RQ", o_RQ, -15);

        // Soft init at k=5
        for (int k = 0; k < 5; k++) send(k, -k, 0, 1'b0);
        send(5, -5, 0, 1'b1);
        check("t4_half_after_init", o_half, 0);
        for (int k = 0; k < 8; k++) send(k + 40, 60 - k, 0, 1'b0);
        idle(LAT + 1);
        check("t4_pairs", vld_cnt, 21);
        check("t4_LI", o_LI, 43);
        check("t4_RQ", o_RQ, 53);

        // Async reset mid phase 1
        for (int k = 0; k < 6; k++) send(k + 1, k + 1, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_async_vld", o_vld, 0);
        check("t5_async_LI", o_LI, 0);
        check("t5_async_RQ", o_RQ, 0);
        check("t5_async_half", o_half, 0);
        idle(1);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) send(3 * k + 1, 100 - k, 0, 1'b0);
        idle(LAT + 1);
        check("t5_pairs", vld_cnt, 25);
        check("t5_LI", o_LI, 10);
        check("t5_RQ", o_RQ, 93);

        // 2-point stage
        send2(1);
        check("t5b_half", o2_half, 1);
        send2(2);
        send2(3);
        send2(4);
        idle(LAT + 1);
        check("t5b_pairs", got2.size(), 2);
        if (got2.size() == 2) begin
            check("t5b_p0_L", got2[0].li, 1);
            check("t5b_p0_R", got2[0].ri, 2);
            check("t5b_p0_strb", got2[0].fs, 1);
            check("t5b_p1_L", got2[1].li, 3);
            check("t5b_p1_R", got2[1].ri, 4);
            check("t5b_p1_strb", got2[1].fs, 1);
        end
        check("t5b_LQ", o2_LQ, -3);

        idle(2);
        check("pending_pairs", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
